// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath sizing for the register file and its writeback logic.
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback/read bundle between the pipeline (master) and the register file (slave).
interface wb_regfile_if #(parameter int XLEN = riscv_pkg::XLEN);
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] memData;
    logic [4:0]      rd;
    logic            MemtoReg;
    logic            RegWrite;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] wbData;
    logic            wbValid;
    logic [31:0]     wrCount;
    modport master (
        output aluResult, memData, rd, MemtoReg, RegWrite, rs1, rs2,
        input  rdata1, rdata2, wbData, wbValid, wrCount
    );
    modport slave (
        input  aluResult, memData, rd, MemtoReg, RegWrite, rs1, rs2,
        output rdata1, rdata2, wbData, wbValid, wrCount
    );
endinterface

// File: rtl/regfile_mem.sv
// regfile_mem: NREG x XLEN storage, one write port, two asynchronous read ports; x0 reads as zero.
module regfile_mem #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NREG,
    parameter int AW   = riscv_pkg::REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);
    logic [XLEN-1:0] regs_q [NREG];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else if (we_i && waddr_i != '0) regs_q[waddr_i] <= wdata_i;
    end
    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback mux, register file and committed-write counter.
// Define WB_REGFILE_BYPASS_EN for write-before-read forwarding on same-cycle index matches.
module wb_regfile #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NREG
) (
    input logic         clk,
    input logic         reset,
    wb_regfile_if.slave bus
);
    localparam int AW = $clog2(NREG);
    logic [XLEN-1:0] wb_data, mem_rd1, mem_rd2;
    logic            wb_valid;
    logic [31:0]     wr_count_q, wr_count_d;
    assign wb_data  = bus.MemtoReg ? bus.memData : bus.aluResult;
    assign wb_valid = bus.RegWrite && (bus.rd != 5'd0);
    regfile_mem #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_mem (
        .clk      (clk),
        .rst_n    (reset),
        .we_i     (wb_valid),
        .waddr_i  (bus.rd[AW-1:0]),
        .wdata_i  (wb_data),
        .raddr1_i (bus.rs1[AW-1:0]),
        .raddr2_i (bus.rs2[AW-1:0]),
        .rdata1_o (mem_rd1),
        .rdata2_o (mem_rd2)
    );
`ifdef WB_REGFILE_BYPASS_EN
    // wb_valid already excludes rd==0, so x0 never picks up forwarded data
    assign bus.rdata1 = (wb_valid && bus.rs1 == bus.rd) ? wb_data : mem_rd1;
    assign bus.rdata2 = (wb_valid && bus.rs2 == bus.rd) ? wb_data : mem_rd2;
`else
    assign bus.rdata1 = mem_rd1;
    assign bus.rdata2 = mem_rd2;
`endif
    assign wr_count_d = wb_valid ? wr_count_q + 32'd1 : wr_count_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wr_count_q <= '0;
        else wr_count_q <= wr_count_d;
    end
    assign bus.wbData  = wb_data;
    assign bus.wbValid = wb_valid;
    assign bus.wrCount = wr_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of writeback mux, x0 handling, bypass, counter wrap and reset.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    wb_regfile_if #(.XLEN(32)) bus ();
    wb_regfile dut (.clk(clk), .reset(reset), .bus(bus));
    initial forever #5 clk = ~clk;

    task automatic drive_write(input logic [4:0] r, input logic [31:0] alu, input logic [31:0] mem, input logic sel);
        @(negedge clk);
        bus.rd = r; bus.aluResult = alu; bus.memData = mem; bus.MemtoReg = sel; bus.RegWrite = 1'b1;
        @(posedge clk); #1;
        bus.RegWrite = 1'b0;
    endtask

    task automatic test_reset;
        bus.aluResult = '0; bus.memData = '0; bus.rd = '0; bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0; bus.rs1 = 5'd5; bus.rs2 = 5'd0;
        #2;
        vectors++; if (bus.rdata1 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata1 got %h exp %h", bus.rdata1, 32'h0); end
        vectors++; if (bus.wrCount !== 32'h0) begin miscompares++; $display("FAIL reset_wrcount got %h exp %h", bus.wrCount, 32'h0); end
        @(negedge clk); reset = 1'b1;
        drive_write(5'd5, 32'h1234, 32'h0, 1'b0);
        vectors++; if (bus.rdata1 !== 32'h1234) begin miscompares++; $display("FAIL x5_written got %h exp %h", bus.rdata1, 32'h1234); end
        vectors++; if (bus.wrCount !== 32'd1) begin miscompares++; $display("FAIL x5_wrcount got %h exp %h", bus.wrCount, 32'd1); end
        @(negedge clk); #2 reset = 1'b0; #1;
        vectors++; if (bus.rdata1 !== 32'h0) begin miscompares++; $display("FAIL async_reset_rdata1 got %h exp %h", bus.rdata1, 32'h0); end
        vectors++; if (bus.wrCount !== 32'h0) begin miscompares++; $display("FAIL async_reset_wrcount got %h exp %h", bus.wrCount, 32'h0); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_wb_mux;
        @(negedge clk);
        bus.aluResult = 32'hAAAA0000; bus.memData = 32'h0000BBBB; bus.MemtoReg = 1'b1; #1;
        vectors++; if (bus.wbData !== 32'h0000BBBB) begin miscompares++; $display("FAIL wbdata_mem got %h exp %h", bus.wbData, 32'h0000BBBB); end
        bus.MemtoReg = 1'b0; #1;
        vectors++; if (bus.wbData !== 32'hAAAA0000) begin miscompares++; $display("FAIL wbdata_alu got %h exp %h", bus.wbData, 32'hAAAA0000); end
        drive_write(5'd7, 32'hAAAA0000, 32'h0000BBBB, 1'b1);
        bus.rs1 = 5'd7; #1;
        vectors++; if (bus.rdata1 !== 32'h0000BBBB) begin miscompares++; $display("FAIL x7_mem got %h exp %h", bus.rdata1, 32'h0000BBBB); end
        vectors++; if (bus.wrCount !== 32'd1) begin miscompares++; $display("FAIL x7_wrcount got %h exp %h", bus.wrCount, 32'd1); end
        drive_write(5'd8, 32'hAAAA0000, 32'h0000BBBB, 1'b0);
        bus.rs2 = 5'd8; #1;
        vectors++; if (bus.rdata2 !== 32'hAAAA0000) begin miscompares++; $display("FAIL x8_alu got %h exp %h", bus.rdata2, 32'hAAAA0000); end
        vectors++; if (bus.wrCount !== 32'd2) begin miscompares++; $display("FAIL x8_wrcount got %h exp %h", bus.wrCount, 32'd2); end
    endtask

    task automatic test_x0;
        @(negedge clk);
        bus.rd = 5'd1; bus.RegWrite = 1'b1; #1;
        vectors++; if (bus.wbValid !== 1'b1) begin miscompares++; $display("FAIL wbvalid_rd1 got %b exp %b", bus.wbValid, 1'b1); end
        bus.RegWrite = 1'b0; #1;
        vectors++; if (bus.wbValid !== 1'b0) begin miscompares++; $display("FAIL wbvalid_nowrite got %b exp %b", bus.wbValid, 1'b0); end
        bus.rd = 5'd0; bus.aluResult = 32'hFFFFFFFF; bus.MemtoReg = 1'b0; bus.RegWrite = 1'b1; #1;
        vectors++; if (bus.wbValid !== 1'b0) begin miscompares++; $display("FAIL wbvalid_x0 got %b exp %b", bus.wbValid, 1'b0); end
        @(posedge clk); #1;
        bus.RegWrite = 1'b0; bus.rs1 = 5'd0; bus.rs2 = 5'd0; #1;
        vectors++; if (bus.rdata2 !== 32'h0) begin miscompares++; $display("FAIL x0_rdata2 got %h exp %h", bus.rdata2, 32'h0); end
        vectors++; if (bus.rdata1 !== 32'h0) begin miscompares++; $display("FAIL x0_rdata1 got %h exp %h", bus.rdata1, 32'h0); end
        vectors++; if (bus.wrCount !== 32'd2) begin miscompares++; $display("FAIL x0_wrcount got %h exp %h", bus.wrCount, 32'd2); end
    endtask

    task automatic test_same_index;
        bus.rs1 = 5'd7; bus.rs2 = 5'd7; #1;
        vectors++; if (bus.rdata1 !== 32'h0000BBBB) begin miscompares++; $display("FAIL same_rdata1 got %h exp %h", bus.rdata1, 32'h0000BBBB); end
        vectors++; if (bus.rdata2 !== 32'h0000BBBB) begin miscompares++; $display("FAIL same_rdata2 got %h exp %h", bus.rdata2, 32'h0000BBBB); end
    endtask

    task automatic test_bypass;
        logic [31:0] exp_pre;
`ifdef WB_REGFILE_BYPASS_EN
        exp_pre = 32'h22;
`else
        exp_pre = 32'h11;
`endif
        drive_write(5'd3, 32'h11, 32'h0, 1'b0);
        @(negedge clk);
        bus.rd = 5'd3; bus.aluResult = 32'h22; bus.MemtoReg = 1'b0; bus.RegWrite = 1'b1;
        bus.rs1 = 5'd3; bus.rs2 = 5'd3; #1;
        vectors++; if (bus.rdata1 !== exp_pre) begin miscompares++; $display("FAIL bypass_rdata1 got %h exp %h", bus.rdata1, exp_pre); end
        vectors++; if (bus.rdata2 !== exp_pre) begin miscompares++; $display("FAIL bypass_rdata2 got %h exp %h", bus.rdata2, exp_pre); end
        @(posedge clk); #1;
        bus.RegWrite = 1'b0; #1;
        vectors++; if (bus.rdata1 !== 32'h22) begin miscompares++; $display("FAIL post_edge_x3 got %h exp %h", bus.rdata1, 32'h22); end
        vectors++; if (bus.wrCount !== 32'd4) begin miscompares++; $display("FAIL bypass_wrcount got %h exp %h", bus.wrCount, 32'd4); end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.wr_count_q = 32'hFFFFFFFF;
        #1 release dut.wr_count_q;
        #1;
        vectors++; if (bus.wrCount !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL wrap_preload got %h exp %h", bus.wrCount, 32'hFFFFFFFF); end
        drive_write(5'd10, 32'h5, 32'h0, 1'b0);
        vectors++; if (bus.wrCount !== 32'h0) begin miscompares++; $display("FAIL wrap_zero got %h exp %h", bus.wrCount, 32'h0); end
        drive_write(5'd11, 32'h6, 32'h0, 1'b0);
        vectors++; if (bus.wrCount !== 32'd1) begin miscompares++; $display("FAIL wrap_one got %h exp %h", bus.wrCount, 32'd1); end
        bus.rs1 = 5'd10; #1;
        vectors++; if (bus.rdata1 !== 32'h5) begin miscompares++; $display("FAIL wrap_x10 got %h exp %h", bus.rdata1, 32'h5); end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        bus.rd = 5'd9; bus.aluResult = 32'h55; bus.MemtoReg = 1'b0; bus.RegWrite = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        bus.RegWrite = 1'b0; reset = 1'b1; bus.rs1 = 5'd9; bus.rs2 = 5'd10; #1;
        vectors++; if (bus.rdata1 !== 32'h0) begin miscompares++; $display("FAIL midreset_x9 got %h exp %h", bus.rdata1, 32'h0); end
        vectors++; if (bus.rdata2 !== 32'h0) begin miscompares++; $display("FAIL midreset_x10 got %h exp %h", bus.rdata2, 32'h0); end
        vectors++; if (bus.wrCount !== 32'h0) begin miscompares++; $display("FAIL midreset_wrcount got %h exp %h", bus.wrCount, 32'h0); end
        drive_write(5'd9, 32'h66, 32'h0, 1'b0);
        vectors++; if (bus.rdata1 !== 32'h66) begin miscompares++; $display("FAIL first_write_x9 got %h exp %h", bus.rdata1, 32'h66); end
        vectors++; if (bus.wrCount !== 32'd1) begin miscompares++; $display("FAIL first_write_wrcount got %h exp %h", bus.wrCount, 32'd1); end
    endtask

    initial begin
        test_reset();
        test_wb_mux();
        test_x0();
        test_same_index();
        test_bypass();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
